// File: rtl/control_unit_fft_iter_gen_pkg.sv
// Shared types and helpers for the iterative radix-2 FFT control unit.
// Holds the FSM state encoding, a constant clog2 and the per-layer butterfly count.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // B = 2^(L-1); an empty transform has no butterflies.
    function automatic int butterflies(input int layers);
        return (layers <= 0) ? 0 : (1 << (layers - 1));
    endfunction

endpackage

// File: rtl/control_unit_fft_iter_gen_strobe_delay_line.sv
// Enable-gated shift register that turns the butterfly read strobe into the
// matching write strobe DEPTH enabled cycles later.
module strobe_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (clr) begin
            sr <= '0;
        end else if (en) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/control_unit_fft_iter_gen.sv
// Control unit for the in-place iterative radix-2 FFT: sequences read strobes,
// address steps, delayed writes and layer advances behind a START/BUSY/DONE handshake.
module control_unit_fft_iter_gen
    import fft_ctrl_pkg::*;
#(
    parameter int LAYERS_MAX = 10,
    parameter int LayWL      = 4,
    parameter int ButtWL     = 9,
    parameter int BUT_CYC    = 2,
    parameter int WR_LAT     = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              START,
    input  logic [LayWL-1:0]  N_LAYERS,
    output logic              BUSY,
    output logic              DONE,
    output logic              BUT_STROB,
    output logic              ADDR_EN,
    output logic              RAM_EN,
    output logic              WR_EN,
    output logic              LAY_EN,
    output logic [LayWL-1:0]  LAY_IDX,
    output logic [ButtWL-1:0] BUT_IDX,
    output logic              FIRST,
    output logic              LAST,
    output state_t            fsm_state
);

    localparam int CNT_MAX = (BUT_CYC > WR_LAT) ? BUT_CYC : WR_LAT;
    localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [LayWL-1:0]   lay_idx, lay_idx_n;
    logic [LayWL-1:0]   lay_num, lay_num_n;
    logic [ButtWL-1:0]  but_idx, but_idx_n;
    logic [ButtWL-1:0]  but_last, but_last_n;
    logic [LayWL-1:0]   l_sat;
    logic               lay_adv;
    logic               is_last_lay;
    logic               in_layer;
    logic               strob_raw;
    logic               wr_raw;

    assign l_sat       = (N_LAYERS > LayWL'(LAYERS_MAX)) ? LayWL'(LAYERS_MAX) : N_LAYERS;
    assign is_last_lay = (lay_idx == lay_num - LayWL'(1));

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lay_idx_n  = lay_idx;
        lay_num_n  = lay_num;
        but_idx_n  = but_idx;
        but_last_n = but_last;
        lay_adv    = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    lay_num_n  = l_sat;
                    but_last_n = ButtWL'(butterflies(int'(l_sat)) - 1);
                    cnt_n      = '0;
                    lay_idx_n  = '0;
                    but_idx_n  = '0;
                    state_n    = (l_sat == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_W'(BUT_CYC - 1)) begin
                    cnt_n = '0;
                    // Hold BUT_IDX at B-1 through the drain so it never wraps.
                    if (but_idx == but_last) state_n = S_GAP;
                    else                     but_idx_n = but_idx + ButtWL'(1);
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(WR_LAT - 1)) begin
                    cnt_n = '0;
                    if (is_last_lay) begin
                        state_n = S_DONE;
                    end else begin
                        lay_adv   = 1'b1;
                        lay_idx_n = lay_idx + LayWL'(1);
                        but_idx_n = '0;
                        state_n   = S_RUN;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                lay_idx_n = '0;
                but_idx_n = '0;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lay_idx  <= '0;
            lay_num  <= '0;
            but_idx  <= '0;
            but_last <= '0;
        end else if (EN) begin
            state    <= state_n;
            cnt      <= cnt_n;
            lay_idx  <= lay_idx_n;
            lay_num  <= lay_num_n;
            but_idx  <= but_idx_n;
            but_last <= but_last_n;
        end
    end

    assign strob_raw = (state == S_RUN) && (cnt == '0);

    strobe_delay_line #(
        .DEPTH (WR_LAT)
    ) u_wr_delay (
        .clk  (CLK),
        .clr  (RST),
        .en   (EN),
        .din  (strob_raw),
        .dout (wr_raw)
    );

    // Pulses are gated by EN; levels come straight from the held registers.
    assign in_layer  = (state == S_RUN) || (state == S_GAP);
    assign BUT_STROB = EN && strob_raw;
    assign ADDR_EN   = EN && (state == S_RUN) && (cnt == CNT_W'(BUT_CYC - 1));
    assign WR_EN     = EN && wr_raw;
    assign RAM_EN    = BUT_STROB || WR_EN;
    assign LAY_EN    = EN && lay_adv;
    assign DONE      = EN && (state == S_DONE);
    assign BUSY      = (state != S_IDLE);
    assign FIRST     = in_layer && (lay_idx == '0);
    assign LAST      = in_layer && is_last_lay;
    assign LAY_IDX   = lay_idx;
    assign BUT_IDX   = but_idx;
    assign fsm_state = state;

endmodule
